// File: rtl/mmul_seq_ctrl_if.sv
// Command/datapath bundle for the Montgomery multiplier sequencer.
// The slave side is the sequencer; the master side is the command/datapath environment.
interface mmul_seq_ctrl_if #(
   parameter int N_ITER = 8,
   parameter int CW     = $clog2(N_ITER + 1)
);
   logic          start;
   logic          abort;
   logic [1:0]    c_flag;
   logic          sub_borrow;
   logic          mmul_en;
   logic          mul_en;
   logic          red_en;
   logic          sub_en;
   logic          regc_we;
   logic          regd_we;
   logic          regb_we;
   logic [1:0]    c_flag_in;
   logic          c_flag_we;
   logic [CW-1:0] iter_cnt;
   logic          busy;
   logic          done;

   modport master (
      output start, abort, c_flag, sub_borrow,
      input  mmul_en, mul_en, red_en, sub_en, regc_we, regd_we, regb_we,
             c_flag_in, c_flag_we, iter_cnt, busy, done
   );

   modport slave (
      input  start, abort, c_flag, sub_borrow,
      output mmul_en, mul_en, red_en, sub_en, regc_we, regd_we, regb_we,
             c_flag_in, c_flag_we, iter_cnt, busy, done
   );
endinterface

// File: rtl/mmul_seq_ctrl.sv
// Sequencer for the word-serial Montgomery multiplier: LOAD, N_ITER x (MUL, RED, WRB), FIN, FWB, DONE.
// Every output is a register loaded with the value belonging to the state being entered.
module mmul_seq_ctrl #(
   parameter int N_ITER = 8,
   parameter int CW     = $clog2(N_ITER + 1)
) (
   input logic           clk,
   input logic           rst,
   mmul_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MUL  = 3'd2,
      S_RED  = 3'd3,
      S_WRB  = 3'd4,
      S_FIN  = 3'd5,
      S_FWB  = 3'd6,
      S_DONE = 3'd7
   } state_t;

   localparam logic [CW-1:0] LAST_ITER = CW'(N_ITER - 1);
   localparam logic [CW-1:0] ONE_ITER  = CW'(1);

   state_t        state_r;
   logic [CW-1:0] iter_cnt_r;
   logic          mmul_en_r;
   logic          mul_en_r;
   logic          red_en_r;
   logic          sub_en_r;
   logic          regc_we_r;
   logic          regd_we_r;
   logic          regb_we_r;
   logic [1:0]    c_flag_in_r;
   logic          c_flag_we_r;
   logic          busy_r;
   logic          done_r;

   // Write-back goes to whichever ping-pong register does not hold c; regb/11 fall back to regc/regd.
   function automatic logic [1:0] wrb_target(input logic [1:0] c_loc);
      case (c_loc)
         2'b01:   return 2'b00;
         2'b10:   return 2'b00;
         default: return 2'b01;
      endcase
   endfunction

   // Sequencer state, iteration counter and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         iter_cnt_r  <= {CW{1'b0}};
         mmul_en_r   <= 1'b0;
         mul_en_r    <= 1'b0;
         red_en_r    <= 1'b0;
         sub_en_r    <= 1'b0;
         regc_we_r   <= 1'b0;
         regd_we_r   <= 1'b0;
         regb_we_r   <= 1'b0;
         c_flag_in_r <= 2'b00;
         c_flag_we_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         mmul_en_r   <= 1'b0;
         mul_en_r    <= 1'b0;
         red_en_r    <= 1'b0;
         sub_en_r    <= 1'b0;
         regc_we_r   <= 1'b0;
         regd_we_r   <= 1'b0;
         regb_we_r   <= 1'b0;
         c_flag_in_r <= 2'b00;
         c_flag_we_r <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b1;
         if (bus.abort && (state_r != S_IDLE)) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               S_IDLE: begin
                  if (bus.start) begin
                     state_r   <= S_LOAD;
                     mmul_en_r <= 1'b1;
                  end else begin
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                  end
               end
               S_LOAD: begin
                  iter_cnt_r <= {CW{1'b0}};
                  state_r    <= S_MUL;
                  mul_en_r   <= 1'b1;
               end
               S_MUL: begin
                  state_r  <= S_RED;
                  red_en_r <= 1'b1;
               end
               // c_flag is stable from the previous write-back, so it can be decoded one cycle early.
               S_RED: begin
                  state_r     <= S_WRB;
                  c_flag_we_r <= 1'b1;
                  c_flag_in_r <= wrb_target(bus.c_flag);
                  regc_we_r   <= (wrb_target(bus.c_flag) == 2'b00);
                  regd_we_r   <= (wrb_target(bus.c_flag) == 2'b01);
               end
               S_WRB: begin
                  iter_cnt_r <= iter_cnt_r + ONE_ITER;
                  if (iter_cnt_r == LAST_ITER) begin
                     state_r  <= S_FIN;
                     sub_en_r <= 1'b1;
                  end else begin
                     state_r  <= S_MUL;
                     mul_en_r <= 1'b1;
                  end
               end
               // The borrow seen at the end of FIN is captured directly in the FWB strobes.
               S_FIN: begin
                  state_r <= S_FWB;
                  if (!bus.sub_borrow) begin
                     regb_we_r   <= 1'b1;
                     c_flag_in_r <= 2'b10;
                     c_flag_we_r <= 1'b1;
                  end else begin
                     regb_we_r <= 1'b0;
                  end
               end
               S_FWB: begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
               end
               S_DONE: begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end
               default: begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.mmul_en   = mmul_en_r;
   assign bus.mul_en    = mul_en_r;
   assign bus.red_en    = red_en_r;
   assign bus.sub_en    = sub_en_r;
   assign bus.regc_we   = regc_we_r;
   assign bus.regd_we   = regd_we_r;
   assign bus.regb_we   = regb_we_r;
   assign bus.c_flag_in = c_flag_in_r;
   assign bus.c_flag_we = c_flag_we_r;
   assign bus.iter_cnt  = iter_cnt_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

endmodule

// File: tb/tb_mmul_seq_ctrl.sv
// Bench for mmul_seq_ctrl: N_ITER=8 and N_ITER=1 instances checked every cycle against
// an offset-from-start model of the operation schedule, under directed and random stimulus.
module tb_mmul_seq_ctrl;

   localparam int NA  = 8;
   localparam int NB  = 1;
   localparam int CWA = $clog2(NA + 1);
   localparam int CWB = $clog2(NB + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mmul_seq_ctrl_if #(.N_ITER(NA), .CW(CWA)) if_a ();
   mmul_seq_ctrl_if #(.N_ITER(NB), .CW(CWB)) if_b ();

   mmul_seq_ctrl #(.N_ITER(NA), .CW(CWA)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   mmul_seq_ctrl #(.N_ITER(NB), .CW(CWB)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

   // Environment c-location flag registers, one per datapath, updated by the DUT strobes.
   logic [1:0] flag_a;
   logic [1:0] flag_b;
   always @(posedge clk) begin
      if (rst)                 flag_a <= 2'b00;
      else if (if_a.mmul_en)   flag_a <= 2'b00;
      else if (if_a.c_flag_we) flag_a <= if_a.c_flag_in;
      if (rst)                 flag_b <= 2'b00;
      else if (if_b.mmul_en)   flag_b <= 2'b00;
      else if (if_b.c_flag_we) flag_b <= if_b.c_flag_in;
   end
   assign if_a.c_flag = flag_a;
   assign if_b.c_flag = flag_b;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: per instance, whether an op is running and the cycle offset from its start.
   int         n_of     [2] = '{NA, NB};
   bit         m_act    [2];
   int         m_k      [2];
   int         m_cnt    [2];
   logic [1:0] m_flag   [2];
   bit         m_borrow [2];

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // {mmul_en, mul_en, red_en, sub_en, regc_we, regd_we, regb_we, c_flag_in[1:0], c_flag_we, busy, done}
   function automatic logic [11:0] exp_vec(input int d);
      logic mm, mu, re, su, rc, rd, rb, we, bz, dn;
      logic [1:0] cf;
      int n, k;
      {mm, mu, re, su, rc, rd, rb, we, bz, dn} = 10'b0;
      cf = 2'b00;
      n  = n_of[d];
      k  = m_k[d];
      if (m_act[d]) begin
         bz = 1'b1;
         if (k == 1) mm = 1'b1;
         else if (k <= 3 * n + 1) begin
            if ((k - 2) % 3 == 0) mu = 1'b1;
            else if ((k - 2) % 3 == 1) re = 1'b1;
            else begin
               we = 1'b1;
               if (m_flag[d] == 2'b01 || m_flag[d] == 2'b10) begin rc = 1'b1; cf = 2'b00; end
               else begin rd = 1'b1; cf = 2'b01; end
            end
         end
         else if (k == 3 * n + 2) su = 1'b1;
         else if (k == 3 * n + 3) begin
            if (!m_borrow[d]) begin rb = 1'b1; cf = 2'b10; we = 1'b1; end
         end
         else dn = 1'b1;
      end
      return {mm, mu, re, su, rc, rd, rb, cf, we, bz, dn};
   endfunction

   function automatic logic [11:0] obs_vec(input int d);
      if (d == 0)
         return {if_a.mmul_en, if_a.mul_en, if_a.red_en, if_a.sub_en, if_a.regc_we, if_a.regd_we,
                 if_a.regb_we, if_a.c_flag_in, if_a.c_flag_we, if_a.busy, if_a.done};
      return {if_b.mmul_en, if_b.mul_en, if_b.red_en, if_b.sub_en, if_b.regc_we, if_b.regd_we,
              if_b.regb_we, if_b.c_flag_in, if_b.c_flag_we, if_b.busy, if_b.done};
   endfunction

   function automatic logic [31:0] obs_cnt(input int d);
      if (d == 0) return 32'(if_a.iter_cnt);
      return 32'(if_b.iter_cnt);
   endfunction

   // Called #1 after a rising edge: check this cycle, drive inputs, advance the model one cycle.
   task automatic cycle(input bit r, input bit [1:0] st, input bit [1:0] ab, input bit [1:0] sb);
      logic [11:0] e;
      int n, k;
      for (int d = 0; d < 2; d++) begin
         chk_eq($sformatf("outs[N=%0d]", n_of[d]), 32'(obs_vec(d)), 32'(exp_vec(d)));
         chk_eq($sformatf("iter_cnt[N=%0d]", n_of[d]), obs_cnt(d), 32'(m_cnt[d]));
      end
      rst             = r;
      if_a.start      = st[0];
      if_b.start      = st[1];
      if_a.abort      = ab[0];
      if_b.abort      = ab[1];
      if_a.sub_borrow = sb[0];
      if_b.sub_borrow = sb[1];
      for (int d = 0; d < 2; d++) begin
         e = exp_vec(d);
         n = n_of[d];
         k = m_k[d];
         if (r) begin
            m_act[d] = 1'b0; m_k[d] = 0; m_cnt[d] = 0; m_flag[d] = 2'b00; m_borrow[d] = 1'b0;
         end else begin
            if (e[11]) m_flag[d] = 2'b00;
            else if (e[2]) m_flag[d] = e[4:3];
            if (!m_act[d]) begin
               if (st[d]) begin m_act[d] = 1'b1; m_k[d] = 1; end
            end else if (ab[d]) begin
               m_act[d] = 1'b0;
            end else begin
               if (k == 1) m_cnt[d] = 0;
               if (k >= 2 && k <= 3 * n + 1 && (k - 2) % 3 == 2) m_cnt[d] = m_cnt[d] + 1;
               if (k == 3 * n + 2) m_borrow[d] = sb[d];
               if (k == 3 * n + 4) m_act[d] = 1'b0;
               else m_k[d] = k + 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      if_a.start = 1'b1; if_b.start = 1'b1;
      if_a.abort = 1'b0; if_b.abort = 1'b0;
      if_a.sub_borrow = 1'b0; if_b.sub_borrow = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         m_act[d] = 1'b0; m_k[d] = 0; m_cnt[d] = 0; m_flag[d] = 2'b00; m_borrow[d] = 1'b0;
      end
      // Reset still asserted with start high: outputs must stay idle.
      cycle(1'b1, 2'b11, 2'b00, 2'b00);
      cycle(1'b0, 2'b00, 2'b00, 2'b00);

      // Full ops: borrow 0, then borrow 1.
      for (int c = 0; c < 40; c++) cycle(1'b0, (c == 0) ? 2'b11 : 2'b00, 2'b00, 2'b00);
      for (int c = 0; c < 40; c++) cycle(1'b0, (c == 0) ? 2'b11 : 2'b00, 2'b00, 2'b11);
      // Abort at t0+10.
      for (int c = 0; c < 40; c++) cycle(1'b0, (c == 0) ? 2'b11 : 2'b00, (c == 10) ? 2'b11 : 2'b00, 2'b00);
      // Re-pulsed start at t0+5 and t0+28 (ignored), new op from t0+29.
      for (int c = 0; c < 70; c++)
         cycle(1'b0, (c == 0 || c == 5 || c == 28 || c == 29) ? 2'b11 : 2'b00, 2'b00, 2'b00);
      // Abort in the DONE cycle, and abort together with start in IDLE.
      for (int c = 0; c < 40; c++)
         cycle(1'b0, (c == 0 || c == 29) ? 2'b11 : 2'b00, (c == 28 || c == 29) ? 2'b01 : 2'b00, 2'b00);
      // Start held high: back-to-back ops with start ignored in DONE.
      for (int c = 0; c < 70; c++) cycle(1'b0, 2'b11, 2'b00, 2'($urandom));

      // Random stimulus.
      for (int c = 0; c < 4000; c++) begin
         cycle(($urandom_range(0, 399) == 0),
               {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
               {($urandom_range(0, 49) == 0), ($urandom_range(0, 49) == 0)},
               2'($urandom));
      end
      cycle(1'b0, 2'b00, 2'b00, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
